counter_seq_ctrl: RTL and testbench
===================================

# counter_seq_ctrl

Sequencing controller for the team's counter datapaths. It loads a start value, paces decrements through a programmable prescaler, and supports pause/resume, clear and one-shot or auto-reload modes. It reports terminal-count and done events to the surrounding control logic. It sits between the user or control FSM and the counter, and issues the per-tick enable that steps the counter stage.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- PRE_DIV, 4, clock cycles per count tick (≥1); prescaler width is clog2(PRE_DIV), minimum 1
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  load/restart request, sampled on the rising clock edge
- stop  input  1  pause request
- clear  input  1  abort to idle; highest priority
- mode  input  1  0 = one-shot, 1 = auto-reload; sampled on every tick
- load_val  input  WIDTH  start value, captured on an accepted start or on a reload
- count  output  WIDTH  current count value (registered)
- cnt_en  output  1  one-cycle pulse, coincident with each count update
- tc  output  1  one-cycle terminal-count pulse
- done  output  1  one-cycle completion pulse (one-shot mode only)
- busy  output  1  high in RUN or PAUSE
- state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

## Operation
- Reset (rst_n low, asynchronous): state=IDLE; count=0; prescaler=0; cnt_en, tc, done and busy all 0.
- Control priority each cycle: clear > stop > start > tick.
- clear, any state: next state IDLE; count=0; prescaler=0; no pulses generated.
- IDLE
  - start with load_val≠0: count←load_val, prescaler←0, go to RUN.
  - start with load_val=0: go to DONE; done and tc pulse; count stays 0.
  - stop is ignored.
- RUN
  - The prescaler increments every cycle.
  - At prescaler=PRE_DIV−1 a tick occurs: prescaler←0, cnt_en=1, count←count−1.
  - Tick with count=1, mode=0: count←0, tc=1, done=1, go to DONE.
  - Tick with count=1, mode=1: count←load_val, tc=1, stay in RUN. If load_val=0 at that point, count←0 and the block goes to DONE with done=1.
  - stop: go to PAUSE. Any tick due in that cycle is suppressed and the prescaler holds its value.
  - start: restart. count←load_val, prescaler←0, no pulses.
- PAUSE
  - count and prescaler hold.
  - start: resume to RUN with the prescaler value retained; load_val is not re-read.
  - stop is ignored.
- DONE
  - count holds 0.
  - start: behaves exactly as start in IDLE.
  - stop is ignored.
- count never underflows; the decrement is applied only when count≥1.

## Timing
- All outputs are registered. Decisions use inputs sampled at rising edge k; results are visible after edge k.
- Start accepted at edge k: with no pauses, the first tick is at edge k+PRE_DIV. The count reaches 0 at edge k+load_val·PRE_DIV.
- done and tc are high for exactly the one cycle following the terminal tick edge.
- Each pause cycle delays every subsequent tick by one cycle.
- clear takes effect at the next edge. rst_n takes effect immediately and may be applied in any state, including mid-tick.

## Test plan
- Reset: drive rst_n low mid-RUN with count=5 -> all outputs 0 and state=00 immediately, without waiting for a clock edge.
- One-shot, WIDTH=8, PRE_DIV=4, load_val=3, start at edge 0 -> cnt_en at edges 4, 8 and 12; count 3→2→1→0; done=tc=1 for one cycle after edge 12; then state=11, busy=0.
- Auto-reload, load_val=2, PRE_DIV=1 -> count 2,1,2,1,…; tc pulses every 2 cycles; done stays 0. Clear at an arbitrary edge -> state=00, count=0.
- Pause/resume, PRE_DIV=4, load_val=2
  - Stop on the cycle a tick is due -> no cnt_en, count holds at 2.
  - Hold paused 5 cycles, then start -> the pending tick occurs 1 cycle after resume.
- Edge cases
  - start with load_val=0 -> state=11 with a done pulse.
  - start and stop together in RUN -> PAUSE.
  - clear and start together -> IDLE.
  - start mid-RUN at count=1 -> reload to load_val with no tc.

Source files
------------

// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle between a sequencing master (user or control FSM)
// and the counter sequencing controller.
interface counter_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             mode;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             cnt_en;
    logic             tc;
    logic             done;
    logic             busy;
    logic [1:0]       state;

    modport master (
        output start, stop, clear, mode, load_val,
        input  count, cnt_en, tc, done, busy, state
    );

    modport slave (
        input  start, stop, clear, mode, load_val,
        output count, cnt_en, tc, done, busy, state
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Counter sequencing controller: loads a start value, paces decrements with a
// prescaler, supports pause/resume, clear, one-shot and auto-reload modes.
module counter_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int PRE_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    counter_seq_ctrl_if.slave  bus
);
    localparam int PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [PW-1:0]    pre_q;
    logic             cnt_en_q;
    logic             tc_q;
    logic             done_q;
    logic             busy_q;

    logic load_nz;
    logic tick;

    assign load_nz = (bus.load_val != '0);
    assign tick    = (pre_q == PRE_LAST);

    // Sequencer FSM; all outputs are registered alongside the state.
    // Priority each cycle: clear > stop > start > tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            pre_q    <= '0;
            cnt_en_q <= 1'b0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cnt_en_q <= 1'b0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
            if (bus.clear) begin
                state_q <= IDLE;
                count_q <= '0;
                pre_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        // stop is ignored here; a zero load completes at once
                        if (bus.start) begin
                            pre_q <= '0;
                            if (load_nz) begin
                                count_q <= bus.load_val;
                                state_q <= RUN;
                                busy_q  <= 1'b1;
                            end else begin
                                count_q <= '0;
                                state_q <= DONE;
                                tc_q    <= 1'b1;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    RUN: begin
                        if (bus.stop) begin
                            // pending tick suppressed, prescaler holds
                            state_q <= PAUSE;
                        end else if (bus.start) begin
                            // silent restart; a zero reload has nothing to count
                            pre_q   <= '0;
                            count_q <= bus.load_val;
                            if (!load_nz) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                            end
                        end else if (tick) begin
                            pre_q    <= '0;
                            cnt_en_q <= 1'b1;
                            if (count_q == WIDTH'(1)) begin
                                tc_q <= 1'b1;
                                if (bus.mode && load_nz) begin
                                    count_q <= bus.load_val;
                                end else begin
                                    count_q <= '0;
                                    done_q  <= 1'b1;
                                    state_q <= DONE;
                                    busy_q  <= 1'b0;
                                end
                            end else if (count_q != '0) begin
                                count_q <= count_q - WIDTH'(1);
                            end
                        end else begin
                            pre_q <= pre_q + PW'(1);
                        end
                    end
                    PAUSE: begin
                        // resume keeps the prescaler phase and current count
                        if (bus.start) begin
                            state_q <= RUN;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.count  = count_q;
    assign bus.cnt_en = cnt_en_q;
    assign bus.tc     = tc_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.state  = state_q;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: a PRE_DIV=4 instance for one-shot, pause and
// edge cases, and a PRE_DIV=1 instance for auto-reload. Expected output events
// (any cycle with cnt_en/tc/done) are queued by stimulus and popped by monitors.
module tb_counter_seq_ctrl;
    typedef struct packed {
        logic [31:0] cyc;
        logic        cnt_en;
        logic [7:0]  count;
        logic        tc;
        logic        done;
        logic [1:0]  state;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    ev_t  qa[$];
    ev_t  qb[$];
    ev_t  ga, ea, gb, eb;
    int   k, r;

    counter_seq_ctrl_if #(.WIDTH(8)) a_if();
    counter_seq_ctrl_if #(.WIDTH(8)) b_if();

    counter_seq_ctrl #(.WIDTH(8), .PRE_DIV(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    counter_seq_ctrl #(.WIDTH(8), .PRE_DIV(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input logic en, input logic [7:0] cnt,
                               input logic t, input logic d, input logic [1:0] st);
        ev_t e;
        e.cyc = c; e.cnt_en = en; e.count = cnt; e.tc = t; e.done = d; e.state = st;
        return e;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic cmp_ev(input string nm, input ev_t g, input ev_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got cyc=%0d en=%b cnt=%0d tc=%b done=%b st=%0d, expected cyc=%0d en=%b cnt=%0d tc=%b done=%b st=%0d",
                     nm, g.cyc, g.cnt_en, g.count, g.tc, g.done, g.state,
                     e.cyc, e.cnt_en, e.count, e.tc, e.done, e.state);
        end
    endtask

    // monitor for instance A
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (a_if.cnt_en || a_if.tc || a_if.done)) begin
            ga = mk(cyc, a_if.cnt_en, a_if.count, a_if.tc, a_if.done, a_if.state);
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL evA unexpected: got cyc=%0d en=%b cnt=%0d tc=%b done=%b, expected no event",
                         ga.cyc, ga.cnt_en, ga.count, ga.tc, ga.done);
            end else begin
                ea = qa.pop_front();
                cmp_ev("evA", ga, ea);
            end
        end
    end

    // monitor for instance B
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (b_if.cnt_en || b_if.tc || b_if.done)) begin
            gb = mk(cyc, b_if.cnt_en, b_if.count, b_if.tc, b_if.done, b_if.state);
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL evB unexpected: got cyc=%0d en=%b cnt=%0d tc=%b done=%b, expected no event",
                         gb.cyc, gb.cnt_en, gb.count, gb.tc, gb.done);
            end else begin
                eb = qb.pop_front();
                cmp_ev("evB", gb, eb);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        a_if.start = 0; a_if.stop = 0; a_if.clear = 0; a_if.mode = 0; a_if.load_val = '0;
        b_if.start = 0; b_if.stop = 0; b_if.clear = 0; b_if.mode = 0; b_if.load_val = '0;
        step(2);
        chk("rst count", a_if.count, 0);
        chk("rst state", a_if.state, 0);
        chk("rst busy", a_if.busy, 0);
        chk("rst pulses", {a_if.cnt_en, a_if.tc, a_if.done}, 0);
        rst_n = 1'b1;
        step(1);

        // one-shot, load 3: ticks at k+4, k+8, k+12
        a_if.load_val = 8'd3; a_if.mode = 0; a_if.start = 1;
        step(1); k = cyc; a_if.start = 0;
        chk("run busy", a_if.busy, 1);
        qa.push_back(mk(k + 4,  1, 8'd2, 0, 0, 2'b01));
        qa.push_back(mk(k + 8,  1, 8'd1, 0, 0, 2'b01));
        qa.push_back(mk(k + 12, 1, 8'd0, 1, 1, 2'b11));
        step(13);
        chk("oneshot state", a_if.state, 3);
        chk("oneshot busy", a_if.busy, 0);
        chk("oneshot done low", a_if.done, 0);
        chk("oneshot count", a_if.count, 0);

        // pause on the tick-due cycle, hold 5 cycles, resume
        a_if.load_val = 8'd2; a_if.start = 1;
        step(1); k = cyc; a_if.start = 0;
        step(3); a_if.stop = 1;
        step(1); a_if.stop = 0;
        chk("pause state", a_if.state, 2);
        chk("pause count", a_if.count, 2);
        chk("pause busy", a_if.busy, 1);
        step(4); a_if.start = 1;
        step(1); r = cyc; a_if.start = 0;
        qa.push_back(mk(r + 1, 1, 8'd1, 0, 0, 2'b01));
        qa.push_back(mk(r + 5, 1, 8'd0, 1, 1, 2'b11));
        step(6);
        chk("resume done state", a_if.state, 3);

        // start+stop together in RUN -> PAUSE; then clear+start -> IDLE
        a_if.load_val = 8'd5; a_if.start = 1;
        step(1); a_if.start = 0;
        step(1); a_if.start = 1; a_if.stop = 1;
        step(1); a_if.start = 0; a_if.stop = 0;
        chk("start+stop state", a_if.state, 2);
        chk("start+stop count", a_if.count, 5);
        a_if.clear = 1; a_if.start = 1;
        step(1); a_if.clear = 0; a_if.start = 0;
        chk("clear+start state", a_if.state, 0);
        chk("clear+start count", a_if.count, 0);
        chk("clear+start busy", a_if.busy, 0);

        // restart at count=1 reloads without tc
        a_if.load_val = 8'd2; a_if.start = 1;
        step(1); k = cyc; a_if.start = 0;
        qa.push_back(mk(k + 4, 1, 8'd1, 0, 0, 2'b01));
        step(4);
        a_if.load_val = 8'd7; a_if.start = 1;
        step(1); a_if.start = 0;
        chk("restart count", a_if.count, 7);
        chk("restart state", a_if.state, 1);
        step(2); a_if.clear = 1;
        step(1); a_if.clear = 0;
        chk("clear state", a_if.state, 0);

        // start with load_val=0 -> DONE with done/tc pulse
        a_if.load_val = 8'd0;
        qa.push_back(mk(cyc + 1, 0, 8'd0, 1, 1, 2'b11));
        a_if.start = 1;
        step(1); a_if.start = 0;
        chk("zero load state", a_if.state, 3);
        step(1);
        chk("zero load done low", a_if.done, 0);

        // auto-reload on PRE_DIV=1 instance: count 1,2,1,2..., tc every 2 cycles
        b_if.load_val = 8'd2; b_if.mode = 1; b_if.start = 1;
        step(1); k = cyc; b_if.start = 0;
        for (int i = 1; i <= 6; i++)
            qb.push_back(mk(k + i, 1, (i % 2 == 1) ? 8'd1 : 8'd2, (i % 2 == 0), 0, 2'b01));
        step(6); b_if.clear = 1;
        step(1); b_if.clear = 0;
        chk("autoreload clear state", b_if.state, 0);
        chk("autoreload clear count", b_if.count, 0);

        // asynchronous reset mid-RUN with count=5
        a_if.load_val = 8'd5; a_if.start = 1;
        step(1); a_if.start = 0;
        step(2);
        chk("pre-reset count", a_if.count, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst count", a_if.count, 0);
        chk("async rst state", a_if.state, 0);
        chk("async rst busy", a_if.busy, 0);
        chk("async rst pulses", {a_if.cnt_en, a_if.tc, a_if.done}, 0);
        @(negedge clk); rst_n = 1'b1;
        step(3);

        chk("qa drained", qa.size(), 0);
        chk("qb drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
